// File: rtl/spi_cmd_frame_rx.sv
// SPI-slave receiver for 48-bit command frames (cmd, 32-bit arg, CRC-8).
// Drives the external CRC stage and hands validated frames to the decoder via valid/ack.
module spi_cmd_frame_rx (
  input  logic        spi_clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        mosi,
  input  logic [7:0]  crc8,
  input  logic        frame_ack,
  output logic        crc_reset,
  output logic        crc_en,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        overrun,
  output logic        abort,
  output logic [7:0]  err_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [5:0] LAST_BIT_IDX = 6'd47;

  logic [1:0]  state_q, state_d;
  logic [47:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic        valid_q, valid_d;
  logic        crc_err_q, crc_err_d;
  logic        overrun_q, overrun_d;
  logic        abort_q, abort_d;
  logic [7:0]  err_count_q, err_count_d;

  logic start;
  logic err_inc;
  logic latch_frame;

  // An idle bus floats high, so a low bit under chip select marks the command MSB.
  assign start = ~cs_n & ~mosi;

  always_comb begin
    crc_en    = ~reset & (((state_q == ST_IDLE) & start) |
                          ((state_q == ST_SHIFT) & ~cs_n));
    crc_reset = reset | (state_q == ST_CHECK) | ((state_q == ST_IDLE) & ~start);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    crc_err_d   = 1'b0;
    overrun_d   = 1'b0;
    abort_d     = 1'b0;
    err_inc     = 1'b0;
    latch_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = {shift_q[46:0], mosi};
          bit_cnt_d = 6'd1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_n) begin
          abort_d   = 1'b1;
          err_inc   = 1'b1;
          shift_d   = '0;
          bit_cnt_d = 6'd0;
          state_d   = ST_IDLE;
        end else begin
          shift_d   = {shift_q[46:0], mosi};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == LAST_BIT_IDX) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // The CRC stage has absorbed all 48 bits; a clean frame leaves zero.
        bit_cnt_d = 6'd0;
        state_d   = ST_IDLE;
        if (crc8 == 8'h00) begin
          if (~valid_q | frame_ack) begin
            latch_frame = 1'b1;
            cmd_d       = shift_q[47:40];
            arg_d       = shift_q[39:8];
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          crc_err_d = 1'b1;
          err_inc   = 1'b1;
        end
      end
      default: begin
        bit_cnt_d = 6'd0;
        state_d   = ST_IDLE;
      end
    endcase

    // A frame latched on the ack edge wins; the ack is consumed by the old frame.
    if (latch_frame) begin
      valid_d = 1'b1;
    end else if (frame_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      valid_q     <= valid_d;
      crc_err_q   <= crc_err_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd         = cmd_q;
  assign arg         = arg_q;
  assign frame_valid = valid_q;
  assign crc_err     = crc_err_q;
  assign overrun     = overrun_q;
  assign abort       = abort_q;
  assign err_count   = err_count_q;

endmodule
